// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MiniSys-1A fetch stage:
//   - default reset / exception vectors
//   - 3-bit redirect-source encoding. The numeric order is the priority order,
//     so a plain magnitude compare decides which redirect wins.
//   - pc_gen state encoding (BOOT / RUN / HOLD)
//   - small helper for word-alignment tests
// Optional feature macro used by importers: PC_ALIGN_CHECK_EN
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h0000_F000;

    // Larger value = higher priority.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_J    = 3'd2,
        SRC_JR   = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } redirect_src_e;

    // A redirect request as seen by the selector and the pending buffer.
    typedef struct packed {
        redirect_src_e src;
        logic [31:0]   target;
    } redirect_t;

    // Fetch state encoding.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // True when the address sits on a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : cpu_pkg

// File: rtl/pc_redirect_buf.sv
// ----------------------------------------------------------------------------
// pc_redirect_buf
// Single-entry store for a redirect that arrives while fetch is stalled.
// A new load is accepted when the buffer is empty or when the offered source
// has equal or higher priority than the one already held, so the most
// important control transfer seen during a stall is the one that survives.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset (empties the buffer)
//   load_i          in   offer a redirect for storage this edge
//   load_src_i      in   source (priority) of the offered redirect
//   load_target_i   in   target address of the offered redirect
//   clear_i         in   empty the buffer this edge (wins over load_i)
//   valid_o         out  a redirect is held
//   target_o        out  held target address
// ----------------------------------------------------------------------------
module pc_redirect_buf
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  redirect_src_e load_src_i,
    input  logic [31:0]   load_target_i,
    input  logic          clear_i,
    output logic          valid_o,
    output logic [31:0]   target_o
);

    logic      valid_q, valid_d;
    redirect_t entry_q, entry_d;
    logic      accept;

    // Equal priority replaces: the later request of the same kind is newer.
    assign accept = load_i && (!valid_q || (load_src_i >= entry_q.src));

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d        = 1'b1;
            entry_d.src    = load_src_i;
            entry_d.target = load_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '{src: SRC_SEQ, target: 32'h0};
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = entry_q.target;

endmodule : pc_redirect_buf

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen
// Program-counter register and next-PC selector for the MiniSys-1A fetch
// stage. Picks the next PC from exception entry, eret, jr, jump, branch or the
// sequential pc_plus4, freezes on stall, and parks a redirect that arrives
// during a stall in pc_redirect_buf until fetch resumes.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   defined   - a misaligned redirect target sends pc to EXC_VEC and pulses
//               align_fault for one cycle
//   undefined - redirect targets are loaded with bits [1:0] cleared
//
// Parameters:
//   RESET_VEC   PC loaded on reset
//   EXC_VEC     exception entry address
//
// Ports:
//   clk               in   system clock, rising edge
//   rst_n             in   synchronous active-low reset
//   pc_plus4          in   sequential successor of pc (external adder)
//   stall             in   hazard unit hold request
//   branch_taken      in   conditional branch resolved taken
//   branch_target     in   branch destination
//   jump              in   J/JAL
//   jump_target       in   jump destination
//   jr                in   JR/JALR
//   jr_target         in   register destination
//   eret              in   return from exception
//   epc_in            in   return address from CP0
//   exc_req           in   exception entry request
//   pc                out  current fetch PC
//   if_valid          out  pc is a valid fetch address this cycle
//   redirect_pending  out  a buffered redirect is waiting
//   align_fault       out  (PC_ALIGN_CHECK_EN only) misaligned target seen
// ----------------------------------------------------------------------------
module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        eret,
    input  logic [31:0] epc_in,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        redirect_pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        align_fault
`endif
);

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;

    // Highest-priority non-exception request this cycle.
    redirect_src_e req_src;
    logic [31:0]   req_target;
    logic          req_any;

    // Pending-buffer controls.
    logic          buf_load;
    logic          buf_clear;
    logic          buf_valid;
    logic [31:0]   buf_target;

    // Redirect chosen at an unstalled edge (new request or pending one).
    logic          sel_redirect;
    logic [31:0]   sel_target;

`ifdef PC_ALIGN_CHECK_EN
    logic          fault_q, fault_d;
`endif

    // ------------------------------------------------------------------
    // Priority mux. Exception entry is handled separately because it is
    // never buffered and it overrides stall.
    // ------------------------------------------------------------------
    always_comb begin
        req_src    = SRC_SEQ;
        req_target = 32'h0;
        if (eret) begin
            req_src    = SRC_ERET;
            req_target = epc_in;
        end else if (jr) begin
            req_src    = SRC_JR;
            req_target = jr_target;
        end else if (jump) begin
            req_src    = SRC_J;
            req_target = jump_target;
        end else if (branch_taken) begin
            req_src    = SRC_BR;
            req_target = branch_target;
        end
    end

    assign req_any = (req_src != SRC_SEQ);

    // ------------------------------------------------------------------
    // Next-state / next-PC logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        sel_redirect = 1'b0;
        sel_target   = 32'h0;
`ifdef PC_ALIGN_CHECK_EN
        fault_d      = 1'b0;
`endif
        case (state_q)
            ST_BOOT: begin
                // One idle cycle out of reset; pc stays at RESET_VEC.
                state_d = ST_RUN;
            end
            default: begin
                if (exc_req) begin
                    pc_d      = EXC_VEC;
                    buf_clear = 1'b1;
                    state_d   = ST_RUN;
                end else if (stall) begin
                    // Freeze pc; park any request (the buffer decides
                    // whether it displaces what it already holds).
                    state_d  = ST_HOLD;
                    buf_load = req_any;
                end else begin
                    // Unstalled edge: a fresh request beats the pending one,
                    // and either way the buffer is spent.
                    state_d   = ST_RUN;
                    buf_clear = 1'b1;
                    if (req_any) begin
                        sel_redirect = 1'b1;
                        sel_target   = req_target;
                    end else if (buf_valid) begin
                        sel_redirect = 1'b1;
                        sel_target   = buf_target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
        endcase

        if (sel_redirect) begin
`ifdef PC_ALIGN_CHECK_EN
            if (is_word_aligned(sel_target)) begin
                pc_d = sel_target;
            end else begin
                pc_d    = EXC_VEC;
                fault_d = 1'b1;
            end
`else
            pc_d = sel_target & ~32'h3;
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign align_fault = fault_q;
`endif

    // ------------------------------------------------------------------
    // Pending redirect buffer
    // ------------------------------------------------------------------
    pc_redirect_buf u_redirect_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (buf_load),
        .load_src_i    (req_src),
        .load_target_i (req_target),
        .clear_i       (buf_clear),
        .valid_o       (buf_valid),
        .target_o      (buf_target)
    );

    assign pc               = pc_q;
    assign if_valid         = (state_q != ST_BOOT);
    assign redirect_pending = buf_valid;

endmodule : pc_gen
